// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchronised rxd, 16x oversampling with 3-sample majority vote,
// optional parity, frame/parity error flags, held valid/ready output and overrun pulse.
module uart_rx_core #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_EN   = 0,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV = (CLK_FREQ_HZ + BAUD_RATE * 8) / (BAUD_RATE * 16);
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_core: clock divider must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_chk
    $error("uart_rx_core: DATA_BITS must be 5..8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e               state_q;
  logic                 rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           sub_q;
  logic [2:0]           bit_idx_q;
  logic                 s7_q, s8_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;
  logic                 commit_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, frame_err_q, parity_err_q, overrun_q, busy_q;

  logic tick;
  logic maj;
  logic par_odd;

  assign tick    = (state_q != S_IDLE) && (cnt_q == CW'(DIV - 1));
  // Third vote is the live sample taken on the sub-count 9 tick.
  assign maj     = (s7_q & s8_q) | (s7_q & rxd_s2_q) | (s8_q & rxd_s2_q);
  assign par_odd = (PARITY_ODD != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rxd_s1_q     <= 1'b1;
      rxd_s2_q     <= 1'b1;
      rxd_prev_q   <= 1'b1;
      cnt_q        <= '0;
      sub_q        <= '0;
      bit_idx_q    <= '0;
      s7_q         <= 1'b1;
      s8_q         <= 1'b1;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      commit_q     <= 1'b0;
      stop_q       <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      overrun_q  <= 1'b0;
      commit_q   <= 1'b0;

      if (state_q == S_IDLE || tick) cnt_q <= '0;
      else                           cnt_q <= cnt_q + CW'(1);

      if (tick) sub_q <= sub_q + 4'd1;
      if (tick && sub_q == 4'd7) s7_q <= rxd_s2_q;
      if (tick && sub_q == 4'd8) s8_q <= rxd_s2_q;

      // Commit lands one cycle after the stop decision; a same-cycle accept frees the slot.
      if (commit_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q    <= shift_q;
          frame_err_q  <= ~stop_q;
          parity_err_q <= perr_q;
          rx_valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (rxd_prev_q && !rxd_s2_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
            sub_q   <= '0;
            perr_q  <= 1'b0;
          end
        end
        S_START: begin
          if (tick && sub_q == 4'd9 && maj) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (tick && sub_q == 4'd15) begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
          end
        end
        S_DATA: begin
          if (tick && sub_q == 4'd9) begin
            shift_q <= {maj, shift_q[DATA_BITS-1:1]};
          end else if (tick && sub_q == 4'd15) begin
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
              state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick && sub_q == 4'd9) begin
            perr_q <= (maj != ((^shift_q) ^ par_odd));
          end else if (tick && sub_q == 4'd15) begin
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick && sub_q == 4'd9) begin
            commit_q <= 1'b1;
            stop_q   <= maj;
            if (maj) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rxd_s2_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 8N1 instance plus an even-parity instance, DIV=4 (64 clk/bit).
module tb_uart_rx_core;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1, rxd_p = 1'b1;
  logic       rx_ready = 1'b1, rx_ready_p = 1'b1;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, frame_err, parity_err, overrun, busy;
  logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

  int n_vec = 0;
  int n_err = 0;

  int         acc_n = 0, vcyc_n = 0, ovr_n = 0, acc_p = 0;
  logic [7:0] last_d = '0, last_dp = '0;
  logic       last_fe = 1'b0, last_pe = 1'b0, last_pep = 1'b0;
  int         base_acc, base_vcyc, base_ovr, base_accp;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLK_FREQ_HZ(1_600_000), .BAUD_RATE(25_000), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_core #(
    .CLK_FREQ_HZ(1_600_000), .BAUD_RATE(25_000), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_ready(rx_ready_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
    .overrun(overrun_p), .busy(busy_p)
  );

  // Observe just after the inactive edge, once the bench's negedge drives have settled.
  always begin
    @(negedge clk);
    #1;
    if (rx_valid) vcyc_n++;
    if (rx_valid && rx_ready) begin
      acc_n++;
      last_d  = rx_data;
      last_fe = frame_err;
      last_pe = parity_err;
    end
    if (overrun) ovr_n++;
    if (rx_valid_p && rx_ready_p) begin
      acc_p++;
      last_dp  = rx_data_p;
      last_pep = parity_err_p;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit p, input logic v, input int n);
    if (p) rxd_p = v;
    else   rxd   = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit p, input logic [7:0] d, input logic par, input logic stp);
    drive(p, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(p, d[i], BIT);
    if (p) drive(p, par, BIT);
    drive(p, stp, BIT);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 0xA5 8N1 with consumer always ready
    base_acc = acc_n; base_vcyc = vcyc_n;
    send(1'b0, 8'hA5, 1'b0, 1'b1);
    drive(1'b0, 1'b1, BIT);
    chk("a5_acc", 32'(acc_n - base_acc), 32'd1);
    chk("a5_vcyc", 32'(vcyc_n - base_vcyc), 32'd1);
    chk("a5_data", 32'(last_d), 32'hA5);
    chk("a5_ferr", 32'(last_fe), 32'd0);
    chk("a5_perr", 32'(last_pe), 32'd0);
    chk("a5_busy", 32'(busy), 32'd0);

    // 20-clk glitch is rejected at the start-bit decision
    base_acc = acc_n; base_vcyc = vcyc_n;
    drive(1'b0, 1'b0, 20);
    chk("fs_busy_hi", 32'(busy), 32'd1);
    drive(1'b0, 1'b1, 60);
    chk("fs_busy_lo", 32'(busy), 32'd0);
    chk("fs_vcyc", 32'(vcyc_n - base_vcyc), 32'd0);
    drive(1'b0, 1'b1, BIT);

    // 0x3C with stop bit 0, then line held low (break)
    base_acc = acc_n;
    send(1'b0, 8'h3C, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 200);
    chk("brk_acc", 32'(acc_n - base_acc), 32'd1);
    chk("brk_data", 32'(last_d), 32'h3C);
    chk("brk_ferr", 32'(last_fe), 32'd1);
    chk("brk_busy", 32'(busy), 32'd1);
    chk("brk_ferr_hold", 32'(frame_err), 32'd1);
    drive(1'b0, 1'b1, 8);
    chk("brk_busy_lo", 32'(busy), 32'd0);
    drive(1'b0, 1'b1, BIT);
    chk("brk_acc_after", 32'(acc_n - base_acc), 32'd1);

    // Even parity: 0x07 has odd popcount, so the correct parity bit is 1
    base_accp = acc_p;
    send(1'b1, 8'h07, 1'b0, 1'b1);
    drive(1'b1, 1'b1, BIT);
    chk("par0_acc", 32'(acc_p - base_accp), 32'd1);
    chk("par0_data", 32'(last_dp), 32'h07);
    chk("par0_perr", 32'(last_pep), 32'd1);
    send(1'b1, 8'h07, 1'b1, 1'b1);
    drive(1'b1, 1'b1, BIT);
    chk("par1_acc", 32'(acc_p - base_accp), 32'd2);
    chk("par1_perr", 32'(last_pep), 32'd0);

    // Overrun: consumer stalled across two back-to-back frames
    rx_ready = 1'b0;
    base_ovr = ovr_n;
    send(1'b0, 8'h11, 1'b0, 1'b1);
    send(1'b0, 8'h22, 1'b0, 1'b1);
    drive(1'b0, 1'b1, BIT);
    chk("ovr_pulses", 32'(ovr_n - base_ovr), 32'd1);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_data", 32'(rx_data), 32'h11);
    chk("ovr_ferr", 32'(frame_err), 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_valid_drop", 32'(rx_valid), 32'd0);
    chk("ovr_acc_data", 32'(last_d), 32'h11);

    // Reset in the middle of data bit 4, then a clean 0x5A
    drive(1'b0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, BIT);
    drive(1'b0, 1'b0, BIT / 2);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    repeat (BIT) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    base_acc = acc_n;
    send(1'b0, 8'h5A, 1'b0, 1'b1);
    drive(1'b0, 1'b1, BIT);
    chk("rst_5a_acc", 32'(acc_n - base_acc), 32'd1);
    chk("rst_5a_data", 32'(last_d), 32'h5A);
    chk("rst_5a_ferr", 32'(last_fe), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
